game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl_pkg.sv | 27 ++
 rtl/game_flow_ctrl_if.sv | 28 ++
 rtl/game_flow_ctrl_frame_down_cnt.sv | 46 ++++
 rtl/game_flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared constants for the game sequencer: state encodings, PS/2 make codes
// and datapath widths, plus the saturating score increment.
package game_pkg;

    localparam int unsigned SCORE_W = 7;
    localparam int unsigned LIFE_W  = 2;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 8;

    // Game state encodings (visible on the state output for VGA overlay select)
    localparam logic [STATE_W-1:0] ST_TITLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd1;
    localparam logic [STATE_W-1:0] ST_HIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_OVER  = 3'd4;

    // PS/2 set-2 make codes
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_PAUSE = 8'h4D;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] max_v);
        return (v >= max_v) ? max_v : v + 1'b1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event inputs from the key decoder / collision datapath and the
// status outputs toward the display path, bundled as one interface.
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic                 frame_tick;
    logic                 key_valid;
    logic [7:0]           key_code;
    logic                 collide;
    logic                 coin;
    logic [SCORE_W-1:0]   score;
    logic [LIFE_W-1:0]    life;
    logic [STATE_W-1:0]   state;
    logic                 run_en;
    logic                 blink;
    logic                 new_game;

    modport master (
        output frame_tick, key_valid, key_code, collide, coin,
        input  score, life, state, run_en, blink, new_game
    );

    modport slave (
        input  frame_tick, key_valid, key_code, collide, coin,
        output score, life, state, run_en, blink, new_game
    );

endinterface

// File: rtl/game_flow_ctrl_frame_down_cnt.sv
// Loadable frame down-counter. Load wins over tick; tick decrements unless
// held or already zero. Exposes the next value so the owner can register
// outputs derived from it without an extra cycle of lag.
module frame_down_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    input  logic         hold_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, else decrement on an unheld tick, else hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && !hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign zero_o     = (cnt_q == '0);
    assign one_o      = (cnt_q == W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: owns game state, score and lives, gates object
// motion via run_en and pulses new_game on TITLE->PLAY. All outputs are
// registered and reflect the qualifying input one cycle later.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned SCORE_MAX   = 99,
    parameter int unsigned HIT_FRAMES  = 60,
    parameter int unsigned OVER_FRAMES = 180
) (
    input  logic             clk,
    input  logic             rst_n,
    game_flow_ctrl_if.slave  bus
);

    localparam logic [LIFE_W-1:0]  LIVES_V = LIFE_W'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SMAX_V  = SCORE_W'(SCORE_MAX);
    localparam logic [CNT_W-1:0]   HIT_V   = CNT_W'(HIT_FRAMES);
    localparam logic [CNT_W-1:0]   OVER_V  = CNT_W'(OVER_FRAMES);

    logic [STATE_W-1:0] state_q,  state_d;
    logic [STATE_W-1:0] resume_q, resume_d;
    logic [SCORE_W-1:0] score_q,  score_d;
    logic [LIFE_W-1:0]  life_q,   life_d;
    logic               run_en_q, run_en_d;
    logic               blink_q,  blink_d;
    logic               new_game_q, new_game_d;

    logic               key_enter, key_pause, key_esc;
    logic               hit_load, hit_freeze, hit_hold;
    logic               over_load, over_hold;
    logic [CNT_W-1:0]   hit_cnt, hit_next;
    logic [CNT_W-1:0]   over_cnt, over_next;
    logic               hit_zero, hit_one, over_zero, over_one;
    logic               unused_cnt;

    assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign key_pause = bus.key_valid && (bus.key_code == KEY_PAUSE);
    assign key_esc   = bus.key_valid && (bus.key_code == KEY_ESC);

    // Invulnerability counter runs only in HIT and freezes on the cycle PAUSE is taken
    assign hit_hold  = (state_q != ST_HIT) || hit_freeze;
    assign over_hold = (state_q != ST_OVER);

    frame_down_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (hit_load),
        .load_val_i (HIT_V),
        .tick_i     (bus.frame_tick),
        .hold_i     (hit_hold),
        .cnt_o      (hit_cnt),
        .cnt_next_o (hit_next),
        .zero_o     (hit_zero),
        .one_o      (hit_one)
    );

    frame_down_cnt #(.W(CNT_W)) u_over_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (over_load),
        .load_val_i (OVER_V),
        .tick_i     (bus.frame_tick),
        .hold_i     (over_hold),
        .cnt_o      (over_cnt),
        .cnt_next_o (over_next),
        .zero_o     (over_zero),
        .one_o      (over_one)
    );

    assign unused_cnt = ^{hit_cnt, over_cnt, over_next};

    // Next-state: ESC beats collide beats P; coin applies in PLAY/HIT regardless
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        score_d    = score_q;
        life_d     = life_q;
        new_game_d = 1'b0;
        hit_load   = 1'b0;
        hit_freeze = 1'b0;
        over_load  = 1'b0;

        case (state_q)
            ST_TITLE: begin
                if (key_enter) begin
                    state_d    = ST_PLAY;
                    score_d    = '0;
                    life_d     = LIVES_V;
                    new_game_d = 1'b1;
                end
            end

            ST_PLAY: begin
                if (bus.coin) begin
                    score_d = sat_inc(score_q, SMAX_V);
                end
                if (key_esc) begin
                    state_d = ST_TITLE;
                end else if (bus.collide) begin
                    if (life_q <= LIFE_W'(1)) begin
                        life_d    = '0;
                        over_load = 1'b1;
                        state_d   = ST_OVER;
                    end else begin
                        life_d   = life_q - 1'b1;
                        hit_load = 1'b1;
                        state_d  = ST_HIT;
                    end
                end else if (key_pause) begin
                    state_d  = ST_PAUSE;
                    resume_d = ST_PLAY;
                end
            end

            ST_HIT: begin
                if (bus.coin) begin
                    score_d = sat_inc(score_q, SMAX_V);
                end
                // Pausing freezes the counter even if a tick lands in the same
                // cycle, so a resumed HIT always has a non-zero count to expire.
                if (key_esc) begin
                    state_d = ST_TITLE;
                end else if (key_pause) begin
                    state_d    = ST_PAUSE;
                    resume_d   = ST_HIT;
                    hit_freeze = 1'b1;
                end else if (bus.frame_tick && (hit_one || hit_zero)) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PAUSE: begin
                if (key_esc) begin
                    state_d = ST_TITLE;
                end else if (key_pause) begin
                    state_d = resume_q;
                end
            end

            ST_OVER: begin
                if (bus.frame_tick && (over_one || over_zero)) begin
                    state_d = ST_TITLE;
                end
            end

            default: begin
                state_d = ST_TITLE;
            end
        endcase

        run_en_d = (state_d == ST_PLAY) || (state_d == ST_HIT);
        blink_d  = (state_d == ST_HIT) && hit_next[3];
    end

    // Game state, score/life and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TITLE;
            resume_q   <= ST_PLAY;
            score_q    <= '0;
            life_q     <= LIVES_V;
            run_en_q   <= 1'b0;
            blink_q    <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            score_q    <= score_d;
            life_q     <= life_d;
            run_en_q   <= run_en_d;
            blink_q    <= blink_d;
            new_game_q <= new_game_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.score    = score_q;
    assign bus.life     = life_q;
    assign bus.run_en   = run_en_q;
    assign bus.blink    = blink_q;
    assign bus.new_game = new_game_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: inputs driven and outputs sampled on the
// falling edge, each step covering exactly one rising edge.
module tb_game_flow_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .LIVES_INIT  (3),
        .SCORE_MAX   (99),
        .HIT_FRAMES  (60),
        .OVER_FRAMES (180)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ft, input logic kv, input logic [7:0] kc,
                        input logic col, input logic cn);
        bus.frame_tick = ft;
        bus.key_valid  = kv;
        bus.key_code   = kc;
        bus.collide    = col;
        bus.coin       = cn;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.collide    = 1'b0;
        bus.coin       = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [7:0] kc);
        step(1'b0, 1'b1, kc, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.collide    = 1'b0;
        bus.coin       = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_state", bus.state, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_life", bus.life, 3);
        chk("rst_run_en", bus.run_en, 0);
        chk("rst_blink", bus.blink, 0);
        chk("rst_new_game", bus.new_game, 0);
        rst_n = 1'b1;
        idle();

        // Unrelated key and P ignored in TITLE
        key(8'h1C);
        chk("title_other_key", bus.state, 0);
        key(8'h4D);
        chk("title_p_key", bus.state, 0);

        // ENTER starts a game
        key(8'h5A);
        chk("start_state", bus.state, 1);
        chk("start_new_game", bus.new_game, 1);
        chk("start_score", bus.score, 0);
        chk("start_life", bus.life, 3);
        chk("start_run_en", bus.run_en, 1);
        idle();
        chk("new_game_one_cycle", bus.new_game, 0);

        // Score saturation
        coins(98);
        chk("score_98", bus.score, 98);
        coins(7);
        chk("score_sat", bus.score, 99);
        chk("sat_life", bus.life, 3);
        chk("sat_state", bus.state, 1);

        // Non-fatal hit: count 60, bit3 set
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("hit_state", bus.state, 2);
        chk("hit_life", bus.life, 2);
        chk("hit_blink_60", bus.blink, 1);
        chk("hit_run_en", bus.run_en, 1);
        ticks(5);
        chk("hit_blink_55", bus.blink, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("hit_collide_ignored_life", bus.life, 2);
        chk("hit_collide_ignored_state", bus.state, 2);
        ticks(25);
        chk("hit_blink_30", bus.blink, 1);

        // Pause freezes the invulnerability count at 30
        key(8'h4D);
        chk("pause_state", bus.state, 3);
        chk("pause_run_en", bus.run_en, 0);
        chk("pause_blink", bus.blink, 0);
        ticks(50);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("pause_state_held", bus.state, 3);
        chk("pause_collide_ignored", bus.life, 2);
        key(8'h4D);
        chk("resume_hit_state", bus.state, 2);
        chk("resume_hit_blink_30", bus.blink, 1);
        ticks(29);
        chk("hit_cnt1_state", bus.state, 2);
        chk("hit_cnt1_blink", bus.blink, 0);
        ticks(1);
        chk("hit_expire_state", bus.state, 1);
        chk("hit_expire_blink", bus.blink, 0);

        // ESC beats a same-cycle collide
        step(1'b0, 1'b1, 8'h76, 1'b1, 1'b0);
        chk("esc_state", bus.state, 0);
        chk("esc_life", bus.life, 2);
        chk("esc_score", bus.score, 99);
        chk("esc_run_en", bus.run_en, 0);

        // New game, build score 7 (one coin inside HIT), lose down to one life
        key(8'h5A);
        chk("game2_score", bus.score, 0);
        chk("game2_life", bus.life, 3);
        coins(6);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("game2_hit1_life", bus.life, 2);
        coins(1);
        chk("hit_coin_score", bus.score, 7);
        ticks(60);
        chk("game2_hit1_done", bus.state, 1);
        // Tick in the PLAY->HIT cycle does not shorten the window
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("game2_hit2_life", bus.life, 1);
        ticks(59);
        chk("tick_on_entry_still_hit", bus.state, 2);
        ticks(1);
        chk("tick_on_entry_expire", bus.state, 1);

        // Fatal collide with coin in the same cycle
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("fatal_score", bus.score, 8);
        chk("fatal_life", bus.life, 0);
        chk("fatal_state", bus.state, 4);
        chk("fatal_run_en", bus.run_en, 0);
        key(8'h5A);
        chk("over_enter_ignored", bus.state, 4);
        ticks(179);
        chk("over_179", bus.state, 4);
        ticks(1);
        chk("over_to_title", bus.state, 0);
        chk("over_score_held", bus.score, 8);
        chk("over_life_held", bus.life, 0);

        // Asynchronous reset mid-HIT
        key(8'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_state", bus.state, 2);
        chk("pre_reset_blink", bus.blink, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", bus.state, 0);
        chk("async_rst_life", bus.life, 3);
        chk("async_rst_score", bus.score, 0);
        chk("async_rst_run_en", bus.run_en, 0);
        chk("async_rst_blink", bus.blink, 0);
        chk("async_rst_new_game", bus.new_game, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_reset_state", bus.state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
